// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receive controller.
// Runs on CLK and is paced by a one-cycle BAUD_TICK enable at OVERSAMPLE x baud.
// RXD is synchronised and the start bit is validated at mid-bit. Each data bit is
// then sampled at mid-bit, followed by optional parity and STOP_BITS stop bits.
// Each frame lands in a ready/ack output register with parity, framing and
// overrun flags.
// Optional feature macro: UART_RX_PARITY_EN. When defined, one parity bit is
// expected after the data bits and PERR is live. When undefined, PERR is tied to 0.
`timescale 1ns/1ps

module uart_rx_ctrl #(
    parameter int DATA_BITS  = 8,   // 5..9, LSB first
    parameter int OVERSAMPLE = 16,  // ticks per bit, even, >= 4
    parameter int STOP_BITS  = 1,   // 1 or 2
    parameter int PARITY_ODD = 0    // 0 = even, 1 = odd
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 BAUD_TICK,
    input  logic                 RXD,
    input  logic                 RXACK,
    output logic [DATA_BITS-1:0] RXDATA,
    output logic                 RXRDY,
    output logic                 PERR,
    output logic                 FERR,
    output logic                 OERR,
    output logic                 BUSY
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = 4;  // holds up to 9 data bits or 2 stop bits

    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    logic [1:0]           sync_q;
    logic                 rxd_s;
    logic                 rxd_prev;

    state_t               state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [BW-1:0]        bit_cnt, bit_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic                 ferr_acc, ferr_d;
    logic                 commit;
    logic                 frame_perr;

`ifdef UART_RX_PARITY_EN
    logic                 perr_acc, perr_d;
`endif

    // Two-flop synchroniser. It resets to the idle-high line level.
    always_ff @(posedge CLK) begin
        if (RST) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], RXD};
    end

    assign rxd_s = sync_q[1];

    // Line level at the previous tick. It resets low, so a line held low out of
    // reset has to be seen high before a falling edge can count as a start.
    always_ff @(posedge CLK) begin
        if (RST)            rxd_prev <= 1'b0;
        else if (BAUD_TICK) rxd_prev <= rxd_s;
    end

    // FSM state and receive datapath registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            ferr_acc <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_acc <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bit_cnt  <= bit_d;
            shreg    <= shreg_d;
            ferr_acc <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_acc <= perr_d;
`endif
        end
    end

    // Next-state logic. Everything advances only on BAUD_TICK. START samples
    // at the half-bit point, then restarts the counter. Every later sample at
    // the counter wrap therefore lands mid-bit.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bit_d   = bit_cnt;
        shreg_d = shreg;
        ferr_d  = ferr_acc;
        commit  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_d  = perr_acc;
`endif
        if (BAUD_TICK) begin
            case (state)
                IDLE: begin
                    if (rxd_prev && !rxd_s) begin
                        state_d = START;
                        cnt_d   = '0;
                        bit_d   = '0;
                        ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
                        perr_d  = 1'b0;
`endif
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt_d   = '0;
                        // A high level at mid start bit was a glitch, not a start.
                        state_d = rxd_s ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == FULL_LAST) begin
                        cnt_d   = '0;
                        shreg_d = {rxd_s, shreg[DATA_BITS-1:1]};
                        if (bit_cnt == DATA_LAST) begin
                            bit_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            bit_d = bit_cnt + BW'(1);
                        end
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == FULL_LAST) begin
                        cnt_d   = '0;
                        perr_d  = ((^shreg) ^ rxd_s) != (PARITY_ODD != 0);
                        state_d = STOP;
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == FULL_LAST) begin
                        cnt_d = '0;
                        if (!rxd_s) ferr_d = 1'b1;
                        // Commit on the last stop sample, half a bit early.
                        // That leaves margin for a back-to-back start edge.
                        if (bit_cnt == STOP_LAST) begin
                            bit_d   = '0;
                            commit  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            bit_d = bit_cnt + BW'(1);
                        end
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef UART_RX_PARITY_EN
    assign frame_perr = perr_d;
`else
    assign frame_perr = 1'b0;
    wire   unused_parity_cfg = (PARITY_ODD != 0);
`endif

    // Ready/ack output register. A commit always overwrites the frame. OERR is
    // set when an unacked frame is replaced. An ack in the commit cycle takes
    // the old frame, so the new one is not an overrun.
    always_ff @(posedge CLK) begin
        if (RST) begin
            RXDATA <= '0;
            RXRDY  <= 1'b0;
            PERR   <= 1'b0;
            FERR   <= 1'b0;
            OERR   <= 1'b0;
        end else if (commit) begin
            RXDATA <= shreg;
            PERR   <= frame_perr;
            FERR   <= ferr_d;
            RXRDY  <= 1'b1;
            if (RXRDY && !RXACK)     OERR <= 1'b1;
            else if (RXRDY && RXACK) OERR <= 1'b0;
        end else if (RXACK && RXRDY) begin
            RXRDY <= 1'b0;
            OERR  <= 1'b0;
        end
    end

    assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at default parameters (8 data bits, x16, 1 stop).
// Follows UART_RX_PARITY_EN so frame length and PERR expectations match the build.
`timescale 1ns/1ps

module tb_uart_rx_ctrl;

    localparam int OS = 16;
    localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB       = 1 + DB + P + 1;
    // Tick index (edge tick = 1) whose edge registers the commit.
    localparam int T_COMMIT = (DB + P + 1) * OS + OS / 2 + 1;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          BAUD_TICK = 1'b0;
    logic          RXD = 1'b0;
    logic          RXACK = 1'b0;
    logic [DB-1:0] RXDATA;
    logic          RXRDY, PERR, FERR, OERR, BUSY;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx_ctrl dut (
        .CLK(CLK), .RST(RST), .BAUD_TICK(BAUD_TICK), .RXD(RXD), .RXACK(RXACK),
        .RXDATA(RXDATA), .RXRDY(RXRDY), .PERR(PERR), .FERR(FERR), .OERR(OERR),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       ack_commit;
        logic       ack_after;
        int         gap;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_oerr;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One baud tick every 4 clocks; returns just after the edge that registers it.
    task automatic tick(input logic ack);
        repeat (3) step();
        BAUD_TICK = 1'b1;
        RXACK     = ack;
        step();
        BAUD_TICK = 1'b0;
        RXACK     = 1'b0;
    endtask

    task automatic ack_pulse();
        RXACK = 1'b1;
        step();
        RXACK = 1'b0;
    endtask

    function automatic logic [15:0] build(input logic [7:0] d, input logic par, input logic stop);
        logic [15:0] f;
        int          i;
        f    = '1;
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) f[1+k] = d[k];
        i = 9;
        if (P == 1) begin
            f[i] = par;
            i++;
        end
        f[i] = stop;
        return f;
    endfunction

    // Drives a whole frame and records the tick at which BUSY rose and fell.
    task automatic send_frame(input logic [15:0] bits, input logic ack_commit,
                              output int t_rise, output int t_fall);
        logic prev;
        int   t;
        t_rise = -1;
        t_fall = -1;
        prev   = BUSY;
        for (int b = 0; b < NB; b++) begin
            RXD = bits[b];
            for (int s = 0; s < OS; s++) begin
                t = b * OS + s + 1;
                tick(ack_commit && (t == T_COMMIT));
                if (BUSY && !prev && t_rise < 0) t_rise = t;
                if (!BUSY && prev && t_fall < 0) t_fall = t;
                prev = BUSY;
            end
        end
        RXD = 1'b1;
    endtask

    initial begin
        logic [15:0] bits;
        int          tr, tf;
        logic        busy_seen;

        //            data   par   stop  ackc  acka gap  exp    perr  ferr  oerr
        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 4, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 4, 8'h07, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h07, 1'b0, 1'b1, 1'b0, 1'b1, 4, 8'h07, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 4, 8'h3C, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h11, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 4, 8'h22, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8'h33, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 4, 8'h44, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 4, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 4, 8'hFF, 1'b0, 1'b0, 1'b0};

        // Reset with the line held low.
        RXD = 1'b0;
        repeat (3) step();
        chk("rst_rxdata", RXDATA, 8'h00);
        chk("rst_rxrdy",  RXRDY, 1'b0);
        chk("rst_perr",   PERR,  1'b0);
        chk("rst_ferr",   FERR,  1'b0);
        chk("rst_oerr",   OERR,  1'b0);
        chk("rst_busy",   BUSY,  1'b0);
        RST = 1'b0;
        busy_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b0);
            busy_seen = busy_seen | BUSY;
        end
        chk("held_low_no_start", busy_seen, 1'b0);
        RXD = 1'b1;
        repeat (4) tick(1'b0);
        chk("idle_busy", BUSY, 1'b0);

        // Table of frames.
        for (int v = 0; v < 10; v++) begin
            bits = build(vecs[v].data, vecs[v].par, vecs[v].stop);
            send_frame(bits, vecs[v].ack_commit, tr, tf);
            chk($sformatf("v%0d_busy_rise", v), tr, 1);
            chk($sformatf("v%0d_commit_tick", v), tf, T_COMMIT);
            chk($sformatf("v%0d_rxdata", v), RXDATA, vecs[v].exp_data);
            chk($sformatf("v%0d_rxrdy", v), RXRDY, 1'b1);
            chk($sformatf("v%0d_perr", v), PERR, (P == 1) ? vecs[v].exp_perr : 1'b0);
            chk($sformatf("v%0d_ferr", v), FERR, vecs[v].exp_ferr);
            chk($sformatf("v%0d_oerr", v), OERR, vecs[v].exp_oerr);
            chk($sformatf("v%0d_busy", v), BUSY, 1'b0);
            if (vecs[v].ack_after) begin
                ack_pulse();
                chk($sformatf("v%0d_ack_rxrdy", v), RXRDY, 1'b0);
                chk($sformatf("v%0d_ack_oerr", v), OERR, 1'b0);
            end
            repeat (vecs[v].gap) tick(1'b0);
            chk($sformatf("v%0d_gap_busy", v), BUSY, 1'b0);
        end

        // False start: low for 4 ticks, rejected at the mid-start sample.
        repeat (4) tick(1'b0);
        RXD = 1'b0;
        for (int t = 1; t <= 20; t++) begin
            tick(1'b0);
            if (t == 4) RXD = 1'b1;
            if (t == 1) chk("fs_busy_t1", BUSY, 1'b1);
            if (t == 8) chk("fs_busy_t8", BUSY, 1'b1);
            if (t == 9) chk("fs_busy_t9", BUSY, 1'b0);
        end
        chk("fs_rxrdy", RXRDY, 1'b0);
        chk("fs_busy_end", BUSY, 1'b0);

        // Reset in the middle of the data bits of 0x55.
        bits = build(8'h55, 1'b0, 1'b1);
        for (int t = 0; t < 60; t++) begin
            RXD = bits[t / OS];
            tick(1'b0);
        end
        chk("mid_busy", BUSY, 1'b1);
        RST = 1'b1;
        repeat (2) step();
        RST = 1'b0;
        chk("mrst_rxdata", RXDATA, 8'h00);
        chk("mrst_busy",   BUSY,  1'b0);
        chk("mrst_rxrdy",  RXRDY, 1'b0);
        RXD = 1'b1;
        repeat (20) tick(1'b0);
        chk("mrst_idle_busy",  BUSY,  1'b0);
        chk("mrst_idle_rxrdy", RXRDY, 1'b0);
        bits = build(8'h81, 1'b0, 1'b1);
        send_frame(bits, 1'b0, tr, tf);
        chk("r81_busy_rise",   tr, 1);
        chk("r81_commit_tick", tf, T_COMMIT);
        chk("r81_rxdata", RXDATA, 8'h81);
        chk("r81_rxrdy",  RXRDY, 1'b1);
        chk("r81_perr",   PERR, 1'b0);
        chk("r81_ferr",   FERR, 1'b0);
        chk("r81_oerr",   OERR, 1'b0);
        ack_pulse();
        chk("r81_ack_rxrdy", RXRDY, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Oversampled UART receive controller; the parametrised successor to the fixed 8-bit RX control unit. Runs on the system clock and uses a one-cycle baud-tick enable instead of a separate receive clock. It synchronises RXD, validates the start bit, samples every bit at mid-period, and checks optional parity and 1–2 stop bits. Each frame is presented on a ready/ack output register with parity, framing and overrun flags.

## Interface
- DATA_BITS, 8: payload width, 5..9, LSB received first.
- OVERSAMPLE, 16: BAUD_TICK pulses per bit; even, ≥4.
- STOP_BITS, 1: stop bits checked, 1 or 2.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity. Used only with UART_RX_PARITY_EN.
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous active-high reset.
- BAUD_TICK  in  1  one-CLK pulse at OVERSAMPLE × baud rate.
- RXD  in  1  asynchronous serial line, idle high.
- RXACK  in  1  consumer has taken RXDATA; honoured only while RXRDY=1.
- RXDATA  out  DATA_BITS  last received payload.
- RXRDY  out  1  RXDATA valid, held until acked.
- PERR  out  1  parity error for the frame in RXDATA.
- FERR  out  1  framing error (a stop bit sampled low) for the frame in RXDATA.
- OERR  out  1  sticky overrun: a frame completed while RXRDY=1 and was not acked.
- BUSY  out  1  FSM not in IDLE.

## Operation
- RXD passes through a 2-flop synchroniser (reset 1) to give rxd_s. rxd_prev is updated from rxd_s on every BAUD_TICK and resets to 0, so a line held low out of reset is ignored until it has been seen high.
- The tick counter is $clog2(OVERSAMPLE) bits wide and advances only on BAUD_TICK.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START: on a BAUD_TICK with rxd_prev=1 and rxd_s=0. The counter clears.
- START: on the tick where count = OVERSAMPLE/2−1, sample rxd_s.
  - If the sample is 1, it is a false start; return to IDLE.
  - If the sample is 0, clear the counter and go to DATA.
- DATA: sample on each tick where count = OVERSAMPLE−1 (the mid-bit point, because of the half-bit offset from START).
  - Shift the sample in LSB-first.
  - After DATA_BITS samples, go to PARITY (macro defined) or to STOP.
- PARITY: sample one bit. The error is (XOR of data bits ^ sampled bit) ≠ PARITY_ODD. Go to STOP.
- STOP: sample STOP_BITS bits. Any low sample marks a framing error.
  - On the final stop sample, commit the frame and go to IDLE in the same cycle. This gives a half-bit margin for back-to-back frames.
- Commit writes RXDATA, PERR, FERR and sets RXRDY=1.
  - If RXRDY was already 1 and RXACK is not asserted in that cycle, set OERR. RXDATA/PERR/FERR are still overwritten with the new frame.
- RXACK with RXRDY=1 clears RXRDY and OERR on the next edge. RXACK with RXRDY=0 is ignored.
- Commit and RXACK in the same cycle: the new frame loads, RXRDY stays 1, and OERR is not set.
- RST at any time, including mid-frame: FSM → IDLE, counter 0, shift register 0. All outputs reset to 0: RXDATA, RXRDY, PERR, FERR, OERR and BUSY.

## Timing
- The synchroniser adds 2 CLK of latency from an RXD edge to rxd_s.
- The start sample is taken OVERSAMPLE/2 ticks after the falling-edge tick.
- Data bit k (k = 0..DATA_BITS−1) is sampled (k+1)·OVERSAMPLE + OVERSAMPLE/2 ticks after that edge.
- Commit happens on the final stop-sample tick. With P = 1 if parity is compiled in, else 0, that tick is N = (DATA_BITS + P + STOP_BITS)·OVERSAMPLE + OVERSAMPLE/2 ticks after the edge.
- RXRDY and all flags are valid on the CLK edge that registers the final stop sample, i.e. the clock edge following the BAUD_TICK cycle.
- BUSY rises on the edge registering start detection and falls on the commit edge.
- No combinational path exists from any input to any output.

## Configuration
- UART_RX_PARITY_EN defined:
  - PARITY state present; one parity bit is expected after the data bits.
  - PERR reflects the parity check.
- UART_RX_PARITY_EN undefined:
  - PARITY state and logic are removed; DATA goes straight to STOP.
  - PERR is tied to 0, and the PARITY_ODD parameter is ignored.

## Test plan
- Defaults, no parity: send 0xA5 (8N1, OVERSAMPLE=16).
  - RXRDY rises 152 ticks after the start edge; RXDATA=0xA5, FERR=0, PERR=0, OERR=0.
  - Pulse RXACK: RXRDY returns to 0 on the next edge.
- Parity on, PARITY_ODD=0:
  - Send 0x07 with parity bit 1 → PERR=0.
  - Resend 0x07 with parity bit 0 → PERR=1, RXDATA=0x07.
- False start: pulse RXD low for 4 ticks, then hold high.
  - BUSY returns to 0 after 8 ticks; RXRDY stays 0.
- Framing error: send 0x3C with the stop bit driven low.
  - RXDATA=0x3C, FERR=1, RXRDY=1. The FSM re-arms only after the line has been sampled high.
- Overrun: send 0x11 then 0x22 back-to-back with no RXACK.
  - After the second commit: RXDATA=0x22, OERR=1.
  - RXACK clears both RXRDY and OERR.
  - Repeat with RXACK coinciding with the commit edge → OERR stays 0.
- Reset: assert RST mid-DATA of 0x55, release, then send 0x81.
  - No output for the aborted frame; RXDATA=0x81 with all flags 0.
  - With RXD held low from reset, no start is detected.
